// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    RESP    = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Winner of arbitration, muxed onto the memory port as one bundle.
  typedef struct packed {
    logic                  we;
    logic [2:0]            func3;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; used for fetch starvation
// tracking and for the optional wait-cycle performance counters.
module mem_arb_starve_ctr #(
  parameter int unsigned W       = 3,
  parameter logic [W-1:0] MAX_VAL = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, updated on the falling edge like the rest of the pipeline.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count  = cnt_q;
  assign at_max = (cnt_q == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store access to one memory port and returns read
// data after a fixed latency. Define MEM_ARB_PERF_EN to add wait-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_func3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_dm_wait
`endif
);

  localparam int         SW       = $clog2(STARVE_MAX + 1);
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [3:0]        lat_q, lat_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  mem_req_t          win;
  logic              grant_ok;
  logic              read_gnt;
  logic              starve_at_max;
  logic [SW-1:0]     starve_cnt_unused;

  // Reset forces every combinational output low in the same cycle.
  assign grant_ok = !reset && ((state_q == IDLE) || (state_q == RESP));

  mem_arb_starve_ctr #(
    .W       (SW),
    .MAX_VAL (SW'(STARVE_MAX))
  ) u_starve (
    .clock  (clock),
    .reset  (reset),
    .inc    (if_req & ~if_gnt),
    .clear  (if_gnt),
    .count  (starve_cnt_unused),
    .at_max (starve_at_max)
  );

  // Arbitration: loads/stores win unless fetch has been denied too long.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    win    = '0;
    if (grant_ok) begin
      if (dm_req && !(if_req && starve_at_max)) begin
        dm_gnt    = 1'b1;
        win.we    = dm_we;
        win.func3 = dm_func3;
        win.addr  = ARB_ADDR_W'(dm_addr);
        win.wdata = ARB_DATA_W'(dm_wdata);
      end else if (if_req) begin
        if_gnt    = 1'b1;
        win.we    = 1'b0;
        win.func3 = FUNC3_WORD;
        win.addr  = ARB_ADDR_W'(if_addr);
        win.wdata = '0;
      end else begin
        win = '0;
      end
    end else begin
      win = '0;
    end
  end

  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = win.we;
  assign mem_func3 = win.func3;
  assign mem_addr  = ADDR_W'(win.addr);
  assign mem_wdata = DATA_W'(win.wdata);
  assign read_gnt  = if_gnt | (dm_gnt & ~dm_we);

  // Next-state: stores finish in the grant cycle, reads wait out the latency.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (read_gnt) begin
          state_d = WAIT_RD;
          lat_d   = LAT_INIT;
          owner_d = if_gnt ? OWN_IF : OWN_DM;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RD: begin
        // Counter hits zero on this edge: capture the returning data now.
        if (lat_q <= 4'd1) begin
          lat_d   = 4'd0;
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = mem_rdata;
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = 4'd0;
      end
    endcase
  end

  // Control and read-data registers.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      lat_q      <= 4'd0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q == WAIT_RD);

`ifdef MEM_ARB_PERF_EN
  logic perf_if_sat_unused;
  logic perf_dm_sat_unused;

  mem_arb_starve_ctr #(
    .W       (32),
    .MAX_VAL (32'hFFFF_FFFF)
  ) u_perf_if (
    .clock  (clock),
    .reset  (reset),
    .inc    (if_req & ~if_gnt),
    .clear  (1'b0),
    .count  (perf_if_wait),
    .at_max (perf_if_sat_unused)
  );

  mem_arb_starve_ctr #(
    .W       (32),
    .MAX_VAL (32'hFFFF_FFFF)
  ) u_perf_dm (
    .clock  (clock),
    .reset  (reset),
    .inc    (dm_req & ~dm_gnt),
    .clear  (1'b0),
    .count  (perf_dm_wait),
    .at_max (perf_dm_sat_unused)
  );
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares a single unified memory port between the instruction-fetch stage and the data-memory (load/store) stage of the 5-stage pipeline. It arbitrates requests and issues one access at a time. Reads are tracked through a fixed memory latency, and read data is returned to the owning requester with a valid pulse. Stalls are exposed to the pipeline through the grant signals.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
MEM_LAT, 2, cycles from read issue to mem_rdata valid; legal range 1..15.
STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets forced priority; must be at least 1.

Ports:
clock  in  1  system clock; all state updates on the falling edge.
reset  in  1  reset, asynchronous, active-high.
if_req  in  1  fetch read request; held with if_addr until if_gnt.
if_addr  in  ADDR_W  fetch byte address.
if_gnt  out  1  fetch request issued this cycle.
if_rvalid  out  1  one-cycle pulse; if_rdata valid.
if_rdata  out  DATA_W  fetch read data.
dm_req  in  1  data request; held with dm_* fields until dm_gnt.
dm_we  in  1  1 = store, 0 = load.
dm_func3  in  3  access size/sign code, passed through to memory.
dm_addr  in  ADDR_W  data byte address.
dm_wdata  in  DATA_W  store data.
dm_gnt  out  1  data request issued this cycle.
dm_rvalid  out  1  one-cycle pulse; dm_rdata valid (loads only).
dm_rdata  out  DATA_W  load data.
mem_en  out  1  one-cycle access strobe.
mem_we  out  1  write enable, qualified by mem_en.
mem_func3  out  3  size code to memory.
mem_addr  out  ADDR_W  access address.
mem_wdata  out  DATA_W  write data.
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read strobe.
busy  out  1  a read is outstanding.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latency counter 0; starve counter 0; owner = IF.
- FSM states: IDLE, WAIT_RD, RESP.
- Grant eligibility: a grant may be issued in IDLE or RESP.
- Arbitration: the data request wins when both are pending, unless the starve counter equals STARVE_MAX; then fetch wins.
- Starve counter:
  - Increments (saturating at STARVE_MAX) in each cycle where if_req=1 and if_gnt=0.
  - Clears on if_gnt.
  - Holds when if_req=0.
- Grant cycle (combinational in the eligible cycle):
  - Exactly one of if_gnt or dm_gnt is asserted; mem_en=1.
  - mem_addr, mem_func3, mem_we and mem_wdata are driven from the winner.
  - A fetch grant drives mem_we=0 and mem_func3=3'b010.
- Store grant: the access completes in the grant cycle. No rvalid pulse is generated, and the FSM stays in or returns to IDLE.
- Read grant:
  - The owner is latched and the latency counter is loaded with MEM_LAT; the FSM enters WAIT_RD and busy=1.
  - In WAIT_RD the counter decrements each cycle, and no grants are issued.
  - When the counter reaches 0, mem_rdata is captured into the owner's rdata register and the FSM enters RESP.
  - With MEM_LAT=1, capture happens on the first WAIT_RD edge.
- RESP: the owner's rvalid is pulsed for one cycle. A new grant may be issued in the same cycle (back-to-back). Next state is WAIT_RD if a read was granted, otherwise IDLE.
- Read data: if_rdata and dm_rdata hold their last value until overwritten by the next response to the same requester.
- Request deassertion: a requester dropping req before its grant is legal; no access is issued for it.
- Reset mid-read: the FSM returns to IDLE immediately and the outstanding read is discarded with no rvalid pulse. Both counters clear and the rdata registers clear to 0.
- Arithmetic: the latency counter is 4 bits and the starve counter is $clog2(STARVE_MAX+1) bits, both unsigned. Addresses and data pass through unmodified.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_if_wait and perf_dm_wait (32 bits each).
  - Each is a saturating count of cycles in which its req=1 and its gnt=0.
  - Both clear on reset.
- Undefined: these ports and counters do not exist, and the functional behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, WAIT_RD, RESP}.
  - typedef enum owner_t {OWN_IF, OWN_DM}.
  - localparam FUNC3_WORD = 3'b010.
  - typedef struct mem_req_t {we, func3, addr, wdata}, used to mux the winner.
- Sub-module mem_arb_starve_ctr is the parameterised saturating starve counter with inc, clear and at_max outputs.
  - It is reused for the two perf counters, instantiated with width 32 and no clear.

Test Plan:
- Single fetch read at addr 0x100, MEM_LAT=2, mem_rdata=0xDEADBEEF -> if_gnt and mem_en in the same cycle; if_rvalid 3 cycles later with if_rdata=0xDEADBEEF; busy=1 in between.
- if_req and dm_req (load, addr 0x2000) asserted together -> dm_gnt first; dm_rvalid follows; if_gnt in the RESP cycle of the load.
- Store to 0x40 with dm_func3=3'b000 and wdata 0xAB -> dm_gnt, mem_en, mem_we and mem_func3=000 all in one cycle; no dm_rvalid; next cycle a grant can be issued to fetch.
- dm_req held continuously with loads and if_req held, STARVE_MAX=4 -> if_gnt is issued at the first eligible cycle after 4 denied cycles; the starve counter then returns to 0.
- Reset asserted during WAIT_RD -> all outputs 0 within the same cycle; no rvalid pulse after reset release; the first request after release is granted normally.
- MEM_ARB_PERF_EN defined, fetch stalled 5 cycles behind a load -> perf_if_wait=5 and perf_dm_wait=0.
